// File: rtl/sequenciador_servo.sv
// Servo position sequencer: steps a 2-bit position code toward a target with a
// settle delay per step, or sweeps 00..11..00 continuously while requested.
module sequenciador_servo #(
  parameter int unsigned TEMPO_PASSO = 10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] destino,
  input  logic       varrer,
  input  logic       parar,
  output logic [1:0] posicao,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam int unsigned CW = (TEMPO_PASSO > 1) ? $clog2(TEMPO_PASSO) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(TEMPO_PASSO - 1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'b000,
    PASSO        = 3'b001,
    ESPERA       = 3'b010,
    CONCLUI      = 3'b011,
    VARRE_PASSO  = 3'b100,
    VARRE_ESPERA = 3'b101
  } estado_t;

  estado_t       estado, estado_prox;
  logic [1:0]    alvo, alvo_prox, pos_prox;
  logic [CW-1:0] cnt, cnt_prox;
  logic          dir, dir_prox, dir_ef;

  always_comb begin
    estado_prox = estado;
    alvo_prox   = alvo;
    pos_prox    = posicao;
    cnt_prox    = cnt;
    dir_prox    = dir;
    // At an end stop the sweep must turn around regardless of the stored flag.
    dir_ef      = (posicao == 2'b11) ? 1'b0 : (posicao == 2'b00) ? 1'b1 : dir;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          alvo_prox   = destino;
          estado_prox = (destino == posicao) ? CONCLUI : PASSO;
        end else if (varrer && !parar) begin
          estado_prox = VARRE_PASSO;
        end
      end
      PASSO: begin
        if (parar) begin
          estado_prox = OCIOSO;
        end else begin
          pos_prox    = (alvo > posicao) ? posicao + 2'd1 : posicao - 2'd1;
          cnt_prox    = '0;
          estado_prox = ESPERA;
        end
      end
      ESPERA: begin
        if (parar) begin
          estado_prox = OCIOSO;
        end else if (cnt == CNT_FIM) begin
          estado_prox = (posicao == alvo) ? CONCLUI : PASSO;
        end else begin
          cnt_prox = cnt + CW'(1);
        end
      end
      CONCLUI: estado_prox = OCIOSO;
      VARRE_PASSO: begin
        if (parar) begin
          estado_prox = OCIOSO;
        end else begin
          pos_prox    = dir_ef ? posicao + 2'd1 : posicao - 2'd1;
          dir_prox    = (pos_prox == 2'b11) ? 1'b0 : (pos_prox == 2'b00) ? 1'b1 : dir_ef;
          cnt_prox    = '0;
          estado_prox = VARRE_ESPERA;
        end
      end
      VARRE_ESPERA: begin
        if (parar) begin
          estado_prox = OCIOSO;
        end else if (cnt == CNT_FIM) begin
          estado_prox = varrer ? VARRE_PASSO : OCIOSO;
        end else begin
          cnt_prox = cnt + CW'(1);
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Status outputs are registered from the next state so they align with estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      posicao   <= '0;
      alvo      <= '0;
      cnt       <= '0;
      dir       <= 1'b1;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= '0;
    end else begin
      estado    <= estado_prox;
      posicao   <= pos_prox;
      alvo      <= alvo_prox;
      cnt       <= cnt_prox;
      dir       <= dir_prox;
      ocupado   <= (estado_prox != OCIOSO);
      pronto    <= (estado_prox == CONCLUI);
      db_estado <= estado_prox;
    end
  end

endmodule

// File: tb/tb_sequenciador_servo.sv
// Bench for sequenciador_servo: expected traces are computed from step timing
// arithmetic (d*(T+1)+1 busy cycles, triangle sweep) rather than a state machine.
module tb_sequenciador_servo;
  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset, iniciar, varrer, parar;
  logic [1:0] destino;
  logic [1:0] posicao;
  logic       ocupado, pronto;
  logic [2:0] db_estado;

  int tests = 0;
  int fails = 0;
  int cur_pos = 0;

  sequenciador_servo #(.TEMPO_PASSO(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .destino(destino),
    .varrer(varrer), .parar(parar), .posicao(posicao), .ocupado(ocupado),
    .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int pos, input int ocu, input int pr, input int db);
    check({tag, ".posicao"}, {30'd0, posicao}, pos);
    check({tag, ".ocupado"}, {31'd0, ocupado}, ocu);
    check({tag, ".pronto"}, {31'd0, pronto}, pr);
    check({tag, ".db_estado"}, {29'd0, db_estado}, db);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Position of a triangle sweep starting at 00 going up, after step i (i=-1: start).
  function automatic int tri_pos(input int i);
    int k;
    if (i < 0) return 0;
    k = (i + 1) % 6;
    return (k <= 3) ? k : 6 - k;
  endfunction

  // Expected outputs e edges after a move request is accepted (no abort).
  task automatic move_expect(input int p, input int t, input int e,
                             output int pos, output int ocu, output int pr, output int db);
    int d, s, total, i, r;
    d = (t > p) ? t - p : p - t;
    s = (t > p) ? 1 : -1;
    total = d * (T + 1);
    if (e < total) begin
      i = e / (T + 1);
      r = e % (T + 1);
      db = (r == 0) ? 1 : 2;
      pos = p + s * ((r == 0) ? i : i + 1);
      ocu = 1; pr = 0;
    end else if (e == total) begin
      db = 3; pos = t; ocu = 1; pr = 1;
    end else begin
      db = 0; pos = t; ocu = 0; pr = 0;
    end
  endtask

  // Move to t; abort_at < 0 means no parar, otherwise parar is applied before that edge.
  task automatic do_move(input int t, input int abort_at, input bit noise);
    int p, d, total, pos, ocu, pr, db, ppos, pocu, ppr, pdb;
    p = cur_pos;
    d = (t > p) ? t - p : p - t;
    total = d * (T + 1);
    for (int e = 0; e <= total + 1; e++) begin
      if (e == 0) begin
        iniciar = 1'b1; destino = 2'(t);
      end else if (noise) begin
        iniciar = 1'($urandom % 2); destino = 2'($urandom % 4); varrer = 1'($urandom % 2);
      end else begin
        iniciar = 1'b0;
      end
      if (e == abort_at) parar = 1'b1;
      tick();
      if (e == abort_at) begin
        move_expect(p, t, e - 1, ppos, pocu, ppr, pdb);
        check_outs("abort", ppos, 0, 0, 0);
        parar = 1'b0; iniciar = 1'b0; varrer = 1'b0;
        cur_pos = ppos;
        return;
      end
      move_expect(p, t, e, pos, ocu, pr, db);
      check_outs("move", pos, ocu, pr, db);
    end
    iniciar = 1'b0; varrer = 1'b0;
    cur_pos = t;
  endtask

  initial begin
    int pos, ocu, pr, db, a, t, ab;
    reset = 1'b1; iniciar = 1'b0; varrer = 1'b0; parar = 1'b0; destino = 2'd0;
    tick(); tick();
    check_outs("reset", 0, 0, 0, 0);
    reset = 1'b0;
    cur_pos = 0;

    // Full-range move 00 -> 11
    do_move(3, -1, 1'b0);

    // Reset from a settled nonzero position
    reset = 1'b1; tick(); check_outs("reset_idle", 0, 0, 0, 0); reset = 1'b0;

    // Reset in the middle of a 00 -> 11 move while posicao = 10
    for (int e = 0; e < T + 3; e++) begin
      iniciar = (e == 0); destino = 2'd3;
      tick();
      move_expect(0, 3, e, pos, ocu, pr, db);
      check_outs("pre_reset", pos, ocu, pr, db);
    end
    check("mid_pos", {30'd0, posicao}, 2);
    reset = 1'b1; tick(); check_outs("mid_reset", 0, 0, 0, 0); reset = 1'b0;
    for (int e = 0; e < 3 * (T + 1); e++) begin
      tick();
      check("post_reset.pronto", {31'd0, pronto}, 0);
    end
    cur_pos = 0;

    // Sweep from 00 (dir up), stopped with parar inside VARRE_ESPERA
    a = 6 * (T + 1) + 2 + int'($urandom % T);
    varrer = 1'b1;
    for (int e = 0; e < a; e++) begin
      tick();
      if (e % (T + 1) == 0) check_outs("sweep", tri_pos(e / (T + 1) - 1), 1, 0, 4);
      else check_outs("sweep", tri_pos(e / (T + 1)), 1, 0, 5);
    end
    parar = 1'b1; tick(); check_outs("sweep_stop", 1, 0, 0, 0);
    parar = 1'b0; varrer = 1'b0;

    // Single sweep step, ended by dropping varrer
    varrer = 1'b1; tick(); check_outs("sweep1", 1, 1, 0, 4);
    varrer = 1'b0;
    for (int e = 1; e <= T; e++) begin
      tick(); check_outs("sweep1", 2, 1, 0, 5);
    end
    tick(); check_outs("sweep1_end", 2, 0, 0, 0);
    cur_pos = 2;

    do_move(2, -1, 1'b0);   // destination equals position
    do_move(3, -1, 1'b0);
    do_move(1, -1, 1'b1);   // ignored requests during the move
    do_move(0, -1, 1'b1);

    for (int n = 0; n < 12; n++) begin
      t = int'($urandom % 4);
      a = (t > cur_pos) ? t - cur_pos : cur_pos - t;
      ab = -1;
      if (a > 0 && ($urandom % 3 == 0)) ab = 1 + int'($urandom % (a * (T + 1)));
      do_move(t, ab, 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequenciador_servo.md
SEQUENCIADOR_SERVO -- requirements
Module: sequenciador_servo

Interface
REQ-001 Parameter: TEMPO_PASSO, 10_000_000, settle time in clock cycles held at each intermediate position (legal range >= 2).
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iniciar  input  1  move request, sampled only in OCIOSO.
REQ-005 destino  input  2  target position code, captured when iniciar is accepted.
REQ-006 varrer  input  1  level; requests continuous sweep 00..11..00 while high.
REQ-007 parar  input  1  level; aborts move or sweep.
REQ-008 posicao  output  2  registered position code, driven into the servo PWM controller's position input.
REQ-009 ocupado  output  1  high in every state except OCIOSO.
REQ-010 pronto  output  1  one-cycle completion pulse.
REQ-011 db_estado  output  3  current state encoding, for debug.

Function
REQ-012 States and db_estado codes SHALL be: OCIOSO=000, PASSO=001, ESPERA=010, CONCLUI=011, VARRE_PASSO=100, VARRE_ESPERA=101; unused codes SHALL return to OCIOSO.
REQ-013 All outputs SHALL be registered Moore outputs.
REQ-014 OCIOSO, iniciar=1: SHALL capture destino into register alvo.
  - If destino == posicao: SHALL go to CONCLUI.
  - Otherwise: SHALL go to PASSO.
REQ-015 OCIOSO, iniciar=0, varrer=1, parar=0: SHALL go to VARRE_PASSO; iniciar SHALL have priority over varrer.
REQ-016 PASSO lasts exactly 1 cycle.
  - On exit: posicao SHALL move one code toward alvo (+1 if alvo>posicao, else -1).
  - Settle counter SHALL be cleared; next state is ESPERA.
REQ-017 ESPERA: counter SHALL increment each cycle; after exactly TEMPO_PASSO cycles in ESPERA:
  - posicao==alvo: SHALL go to CONCLUI.
  - Otherwise: SHALL go to PASSO.
REQ-018 CONCLUI lasts 1 cycle with pronto=1, then SHALL go to OCIOSO.
REQ-019 A move of d steps SHALL hold ocupado high for d*(TEMPO_PASSO+1)+1 cycles.
REQ-020 VARRE_PASSO lasts 1 cycle; on exit posicao SHALL step by the direction flag dir (reset value up).
  - If the new posicao is 11 or 00, dir SHALL invert.
  - Next state is VARRE_ESPERA.
REQ-021 VARRE_ESPERA SHALL count TEMPO_PASSO cycles; then:
  - varrer=1: SHALL go to VARRE_PASSO.
  - varrer=0: SHALL go to OCIOSO.
  - pronto is not pulsed on sweep exit.
REQ-022 parar=1 in PASSO, ESPERA, VARRE_PASSO or VARRE_ESPERA SHALL force OCIOSO on the next edge.
  - posicao SHALL hold its current value (no step taken in that cycle).
  - pronto SHALL stay 0.
REQ-023 iniciar, destino and varrer changes SHALL be ignored while ocupado=1.
REQ-024 Counter width SHALL be the minimum needed to reach TEMPO_PASSO-1; posicao SHALL never wrap past 00 or 11.

Reset
REQ-025 reset=1 SHALL, on the next edge and from any state including mid-move, set:
  - posicao=00, ocupado=0, pronto=0, db_estado=000.
  - alvo=00, counter=0, dir=up.
REQ-026 reset SHALL take priority over parar, iniciar and varrer.

Verification (TEMPO_PASSO=4)
REQ-027 Apply reset for 2 cycles -> posicao=00, ocupado=0, pronto=0, db_estado=000.
REQ-028 From 00, pulse iniciar with destino=11:
  - posicao steps 01, 10, 11, each change 5 cycles apart.
  - ocupado stays high for 16 cycles.
  - pronto pulses once, 1 cycle, after 11 has been held for 4 cycles.
REQ-029 With posicao=10, pulse iniciar with destino=10 -> ocupado=1 and pronto=1 for one cycle each; posicao unchanged.
REQ-030 From 11, request destino=01; during the move pulse iniciar with destino=00:
  - Second request ignored.
  - Final posicao=01; exactly one pronto pulse.
REQ-031 Sweep from 00 with varrer held high:
  - posicao sequence 01, 10, 11, 10, 01, 00, 01 at 5-cycle spacing.
  - Assert parar during VARRE_ESPERA -> db_estado=000 next cycle, posicao held, pronto=0.
REQ-032 During a 00->11 move, assert reset while posicao=10 -> posicao=00, ocupado=0 on the next edge, and no pronto pulse.
